// File: rtl/ext_irq_pkg.sv
// Shared definitions for the external interrupt controller.
// Holds the default source/priority/ID sizing and the FSM state encoding.
package ext_irq_pkg;

    localparam int unsigned DEF_NUM_SRC = 8;
    localparam int unsigned DEF_PRIO_W  = 3;
    localparam int unsigned DEF_ID_W    = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTIFY  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/ext_irq_prio_tree.sv
// Combinational max-priority reduction over eligible sources.
// Ports:
//   eligible   - per-source eligibility (pending, enabled, above threshold)
//   prio       - flattened priorities, source i at [i*PRIO_W +: PRIO_W]
//   winner_c   - ID of the highest-priority eligible source (lowest ID on ties)
//   any_elig_c - at least one source is eligible
module ext_irq_prio_tree
    import ext_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned PRIO_W  = DEF_PRIO_W,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic [NUM_SRC-1:0]        eligible,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]           winner_c,
    output logic                      any_elig_c
);

    logic [PRIO_W-1:0] best_prio;

    // Ascending scan with strict '>' so an equal priority never displaces a lower ID.
    always_comb begin
        winner_c   = '0;
        any_elig_c = 1'b0;
        best_prio  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (eligible[i] && (!any_elig_c || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
                winner_c   = ID_W'(i);
                best_prio  = prio[i*PRIO_W +: PRIO_W];
                any_elig_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller in front of the core's external_interrupt input.
// Gateways latch per-source requests, the priority tree picks a winner, and a
// small FSM runs the claim/complete handshake with the trap handler.
// Build option: define IRQ_EDGE_EN for edge-triggered gateways (default is level).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   src_irq, src_en     - peripheral request lines and per-source enables
//   src_prio, threshold - flattened per-source priorities, notification threshold
//   claim_req           - handler claim pulse; claim_id/claim_vld return the result
//   cmpl_vld, cmpl_id   - handler completion pulse and the ID being completed
//   core_wfi            - core is waiting for interrupt
//   external_interrupt  - registered interrupt line to the core
//   core_wake           - registered wake request while in WFI
//   cmpl_err            - sticky flag for completions of IDs not in service
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned PRIO_W  = DEF_PRIO_W,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic [ID_W-1:0]           claim_id,
    output logic                      claim_vld,
    input  logic                      cmpl_vld,
    input  logic [ID_W-1:0]           cmpl_id,
    input  logic                      core_wfi,
    output logic                      external_interrupt,
    output logic                      core_wake,
    output logic                      cmpl_err
);

    irq_state_e state, state_nxt;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] cmpl_mask;
    logic [NUM_SRC-1:0] pend_set;
    logic [ID_W-1:0]    winner;
    logic               any_elig;

    logic claim_fire_c;
    logic cmpl_ok_c;
    logic cmpl_bad_c;
    logic ext_irq_c;

    // Eligibility: pending, enabled and strictly above threshold.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            eligible[i] = pending[i] & src_en[i] &
                          (src_prio[i*PRIO_W +: PRIO_W] > threshold);
        end
    end

    ext_irq_prio_tree #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_prio_tree (
        .eligible   (eligible),
        .prio       (src_prio),
        .winner_c   (winner),
        .any_elig_c (any_elig)
    );

    // One-hot views of the claimed winner and the completed (in-service) source.
    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            claim_mask[i] = claim_fire_c && (winner == ID_W'(i));
            cmpl_mask[i]  = cmpl_ok_c && (claim_id == ID_W'(i));
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NUM_SRC-1:0] src_irq_d;
    logic [NUM_SRC-1:0] edge_latch;
    logic [NUM_SRC-1:0] rise;

    assign rise = src_irq & ~src_irq_d;

    // An edge seen while in service (or on the completion cycle) is promoted at completion.
    assign pend_set = (rise & ~in_service) | (cmpl_mask & (edge_latch | rise));

    // Edge history and the one-deep latch for edges arriving during service.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_irq_d  <= '0;
            edge_latch <= '0;
        end else begin
            src_irq_d  <= src_irq;
            edge_latch <= (edge_latch | (rise & in_service)) & ~cmpl_mask;
        end
    end
`else
    // Level gateway: the in_service check uses the pre-completion value, so a
    // source completed this cycle can only re-pend on the following cycle.
    assign pend_set = src_irq & ~pending & ~in_service;
`endif

    // Gateway state: pending moves to in_service on claim, in_service clears on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= (pending & ~claim_mask) | pend_set;
            in_service <= (in_service & ~cmpl_mask) | claim_mask;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nxt = NOTIFY;
                end
            end
            NOTIFY: begin
                if (!any_elig) begin
                    state_nxt = IDLE;
                end else if (claim_req) begin
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (cmpl_vld && (cmpl_id == claim_id)) begin
                    state_nxt = any_elig ? NOTIFY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM decoded actions; every completion that is not a valid one is an error.
    always_comb begin
        claim_fire_c = (state == NOTIFY) && claim_req && any_elig;
        cmpl_ok_c    = (state == SERVICE) && cmpl_vld && (cmpl_id == claim_id);
        cmpl_bad_c   = cmpl_vld && !cmpl_ok_c;
        ext_irq_c    = (state == NOTIFY);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            claim_id           <= '0;
            claim_vld          <= 1'b0;
            cmpl_err           <= 1'b0;
            external_interrupt <= 1'b0;
            core_wake          <= 1'b0;
        end else begin
            if (claim_fire_c) begin
                claim_id <= winner;
            end
            claim_vld          <= claim_fire_c;
            cmpl_err           <= cmpl_err | cmpl_bad_c;
            external_interrupt <= ext_irq_c;
            core_wake          <= core_wfi & any_elig;
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: a cycle table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_ext_irq_ctrl;

    localparam int NS = 8;
    localparam int PW = 3;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   src_irq;
    logic [NS-1:0]   src_en;
    logic [NS*PW-1:0] src_prio;
    logic [PW-1:0]   threshold;
    logic            claim_req;
    logic [IW-1:0]   claim_id;
    logic            claim_vld;
    logic            cmpl_vld;
    logic [IW-1:0]   cmpl_id;
    logic            core_wfi;
    logic            external_interrupt;
    logic            core_wake;
    logic            cmpl_err;

    always #5 clk = ~clk;

    ext_irq_ctrl #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) dut (
        .clk                (clk),
        .rst                (rst),
        .src_irq            (src_irq),
        .src_en             (src_en),
        .src_prio           (src_prio),
        .threshold          (threshold),
        .claim_req          (claim_req),
        .claim_id           (claim_id),
        .claim_vld          (claim_vld),
        .cmpl_vld           (cmpl_vld),
        .cmpl_id            (cmpl_id),
        .core_wfi           (core_wfi),
        .external_interrupt (external_interrupt),
        .core_wake          (core_wake),
        .cmpl_err           (cmpl_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: which sources await service, which one ID is being
    // serviced (-1 for none), whether the core is being notified, and the
    // values the registered outputs should show after the current edge.
    bit m_pend[NS];
    int m_serving;
    bit m_notify;
    bit m_ext, m_cvld, m_err, m_wake;
    int m_cid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'(src_prio[i*PW +: PW]);
    endfunction

    task automatic model_step();
        int  best;
        int  phase;
        bit  claim;
        bit  ok;
        bit  np[NS];
        if (rst) begin
            m_pend    = '{default: 1'b0};
            m_serving = -1;
            m_notify  = 1'b0;
            m_ext     = 1'b0;
            m_cvld    = 1'b0;
            m_cid     = 0;
            m_err     = 1'b0;
            m_wake    = 1'b0;
            return;
        end
        // Search priority levels from the top down; first hit at a level is the lowest ID.
        best = -1;
        for (int p = (1 << PW) - 1; p > int'(threshold) && best < 0; p--) begin
            for (int i = 0; i < NS && best < 0; i++) begin
                if (m_pend[i] && src_en[i] && prio_of(i) == p) best = i;
            end
        end
        phase  = (m_serving >= 0) ? 2 : (m_notify ? 1 : 0);
        m_ext  = (phase == 1);
        claim  = (phase == 1) && claim_req && (best >= 0);
        ok     = (phase == 2) && cmpl_vld && (int'(cmpl_id) == m_serving);
        if (cmpl_vld && !ok) m_err = 1'b1;
        m_wake = core_wfi && (best >= 0);
        m_cvld = claim;
        if (claim) m_cid = best;
        for (int i = 0; i < NS; i++) begin
            np[i] = m_pend[i];
            if (claim && i == best) np[i] = 1'b0;
            if (src_irq[i] && !m_pend[i] && m_serving != i) np[i] = 1'b1;
        end
        m_pend = np;
        if (claim) begin
            m_serving = best;
            m_notify  = 1'b0;
        end else if (ok) begin
            m_serving = -1;
            m_notify  = (best >= 0);
        end else if (phase == 0) begin
            m_notify = (best >= 0);
        end else if (phase == 1 && best < 0) begin
            m_notify = 1'b0;
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_ext",  32'(external_interrupt), 32'(m_ext));
        chk("m_cvld", 32'(claim_vld),          32'(m_cvld));
        chk("m_cid",  32'(claim_id),           32'(m_cid));
        chk("m_err",  32'(cmpl_err),           32'(m_err));
        chk("m_wake", 32'(core_wake),          32'(m_wake));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_irq   = '0;
        claim_req = 1'b0;
        cmpl_vld  = 1'b0;
        cmpl_id   = '0;
        core_wfi  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ext(input int budget);
        int n = 0;
        while (!external_interrupt && n < budget) begin
            tick();
            n++;
        end
        chk("ext_wait", 32'(external_interrupt), 32'd1);
    endtask

    task automatic claim_once();
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic complete(input int id);
        cmpl_vld = 1'b1;
        cmpl_id  = IW'(id);
        tick();
        cmpl_vld = 1'b0;
        cmpl_id  = '0;
    endtask

    typedef struct {
        logic [NS-1:0] irq;
        logic          claim;
        logic          cmpl;
        logic [IW-1:0] cid_in;
        logic          ext;
        logic          cvld;
        logic [IW-1:0] cid;
    } vec_t;

    vec_t vec[15];
    int   exp2[3];

    initial begin
        rst       = 1'b1;
        src_irq   = '0;
        src_en    = '1;
        src_prio  = '0;
        threshold = '0;
        claim_req = 1'b0;
        cmpl_vld  = 1'b0;
        cmpl_id   = '0;
        core_wfi  = 1'b0;
        m_serving = -1;

        // Single source level-triggered flow, one row per clock.
        vec[0]  = '{8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0};
        vec[1]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0};
        vec[2]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0};
        vec[3]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0};
        vec[4]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0};
        vec[5]  = '{8'h04, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd2};
        vec[6]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2};
        vec[7]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2};
        vec[8]  = '{8'h04, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 5'd2};
        vec[9]  = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2};
        vec[10] = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2};
        vec[11] = '{8'h04, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2};
        vec[12] = '{8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd2};
        vec[13] = '{8'h00, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 5'd2};
        vec[14] = '{8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2};

        do_reset();
        chk("rst_ext",  32'(external_interrupt), 32'd0);
        chk("rst_cvld", 32'(claim_vld),          32'd0);
        chk("rst_cid",  32'(claim_id),           32'd0);
        chk("rst_err",  32'(cmpl_err),           32'd0);
        chk("rst_wake", 32'(core_wake),          32'd0);

        src_prio[2*PW +: PW] = 3'd3;
        for (int k = 0; k < 15; k++) begin
            src_irq   = vec[k].irq;
            claim_req = vec[k].claim;
            cmpl_vld  = vec[k].cmpl;
            cmpl_id   = vec[k].cid_in;
            tick();
            chk($sformatf("t1_ext_%0d", k),  32'(external_interrupt), 32'(vec[k].ext));
            chk($sformatf("t1_cvld_%0d", k), 32'(claim_vld),          32'(vec[k].cvld));
            chk($sformatf("t1_cid_%0d", k),  32'(claim_id),           32'(vec[k].cid));
        end
        claim_req = 1'b0;
        cmpl_vld  = 1'b0;
        cmpl_id   = '0;

        // Priority order with a tie between IDs 4 and 6.
        do_reset();
        src_prio = '0;
        src_prio[1*PW +: PW] = 3'd2;
        src_prio[4*PW +: PW] = 3'd5;
        src_prio[6*PW +: PW] = 3'd5;
        exp2 = '{4, 6, 1};
        src_irq = 8'b0101_0010;
        tick();
        src_irq = '0;
        for (int k = 0; k < 3; k++) begin
            wait_ext(8);
            claim_once();
            chk($sformatf("t2_cvld_%0d", k), 32'(claim_vld), 32'd1);
            chk($sformatf("t2_cid_%0d", k),  32'(claim_id),  32'(exp2[k]));
            complete(exp2[k]);
        end

        // Threshold and enable gating.
        do_reset();
        src_prio = '0;
        src_prio[3*PW +: PW] = 3'd2;
        threshold = 3'd2;
        src_irq = 8'h08;
        tick();
        src_irq = '0;
        for (int k = 0; k < 5; k++) tick();
        chk("t3_thr_block", 32'(external_interrupt), 32'd0);
        threshold = 3'd1;
        tick();
        chk("t3_thr_lat1", 32'(external_interrupt), 32'd0);
        tick();
        chk("t3_thr_pass", 32'(external_interrupt), 32'd1);
        src_en[3] = 1'b0;
        tick();
        tick();
        chk("t3_en_drop", 32'(external_interrupt), 32'd0);
        src_en[3] = 1'b1;
        tick();
        tick();
        chk("t3_still_pending", 32'(external_interrupt), 32'd1);
        claim_once();
        chk("t3_cid", 32'(claim_id), 32'd3);
        complete(3);
        threshold = '0;

        // Bad completion while servicing ID 5.
        do_reset();
        src_prio = '0;
        src_prio[5*PW +: PW] = 3'd4;
        src_irq = 8'h20;
        tick();
        src_irq = '0;
        wait_ext(8);
        claim_once();
        chk("t4_cid", 32'(claim_id), 32'd5);
        complete(3);
        chk("t4_err_set", 32'(cmpl_err), 32'd1);
        claim_once();
        chk("t4_no_claim_in_service", 32'(claim_vld), 32'd0);
        chk("t4_ext_in_service", 32'(external_interrupt), 32'd0);
        complete(5);
        chk("t4_err_sticky", 32'(cmpl_err), 32'd1);
        tick();
        tick();
        chk("t4_idle", 32'(external_interrupt), 32'd0);
        src_irq = 8'h20;
        tick();
        src_irq = '0;
        tick();
        tick();
        chk("t4_renotify", 32'(external_interrupt), 32'd1);
        do_reset();
        chk("t4_err_rst", 32'(cmpl_err), 32'd0);

        // WFI wake request.
        src_prio = '0;
        src_prio[0 +: PW] = 3'd7;
        core_wfi = 1'b1;
        src_irq = 8'h01;
        tick();
        src_irq = '0;
        tick();
        chk("t5_wake", 32'(core_wake), 32'd1);
        core_wfi = 1'b0;
        tick();
        chk("t5_wake_drop", 32'(core_wake), 32'd0);

        // Reset while a claim is in service, with the source still requesting.
        do_reset();
        src_prio = '0;
        src_prio[2*PW +: PW] = 3'd3;
        src_irq = 8'h04;
        wait_ext(8);
        claim_once();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_ext",  32'(external_interrupt), 32'd0);
        chk("t6_cvld", 32'(claim_vld),          32'd0);
        chk("t6_cid",  32'(claim_id),           32'd0);
        chk("t6_err",  32'(cmpl_err),           32'd0);
        chk("t6_wake", 32'(core_wake),          32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_ext_early", 32'(external_interrupt), 32'd0);
        tick();
        chk("t6_renotify", 32'(external_interrupt), 32'd1);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                src_prio  = (NS*PW)'($urandom);
                threshold = PW'($urandom_range(0, 3));
            end
            src_irq   = src_irq ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
            src_en    = ~(NS'($urandom) & NS'($urandom) & NS'($urandom));
            claim_req = ($urandom_range(0, 3) == 0);
            cmpl_vld  = ($urandom_range(0, 4) == 0);
            if (m_serving >= 0 && $urandom_range(0, 3) != 0) cmpl_id = IW'(m_serving);
            else cmpl_id = IW'($urandom);
            if ($urandom_range(0, 7) == 0) core_wfi = ~core_wfi;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
